// File: rtl/cheri_pkg.sv
// Shared CHERI types: host-side operation encoding for the temporal-safety map.
package cheri_pkg;

    localparam int unsigned TSMAP_OP_W = 2;

    typedef enum logic [TSMAP_OP_W-1:0] {
        TSMAP_OP_READ  = 2'd0,
        TSMAP_OP_WRITE = 2'd1,
        TSMAP_OP_BSET  = 2'd2,
        TSMAP_OP_BCLR  = 2'd3
    } tsmap_op_e;

endpackage

// File: rtl/ibexc_tsmap_arbiter.sv
// Shares the single-port TS map SRAM between the core load filter (absolute priority)
// and a host port that can read, write and atomically set/clear revocation bits.
module ibexc_tsmap_arbiter
    import cheri_pkg::*;
#(
    parameter int unsigned TSMapSize = 1024,
    parameter int unsigned AddrW     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  core_cs_i,
    input  logic [AddrW-1:0]      core_addr_i,
    output logic [31:0]           core_rdata_o,

    input  logic                  host_req_i,
    output logic                  host_gnt_o,
    input  logic [TSMAP_OP_W-1:0] host_op_i,
    input  logic [AddrW-1:0]      host_addr_i,
    input  logic [3:0]            host_be_i,
    input  logic [31:0]           host_wdata_i,
    output logic                  host_rvalid_o,
    output logic [31:0]           host_rdata_o,
    output logic                  host_err_o,

    output logic                  sram_cs_o,
    output logic                  sram_we_o,
    output logic [AddrW-1:0]      sram_addr_o,
    output logic [31:0]           sram_wmask_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i,

    output logic                  busy_o
);

    typedef enum logic {ST_IDLE, ST_RMW_WR} state_e;

    state_e           state_q;
    logic             core_rd_q, rd_pend_q, rmw_done_q, rvalid_q, err_q;
    logic             rmw_first_q, rmw_set_q;
    logic [AddrW-1:0] rmw_addr_q;
    logic [31:0]      rmw_mask_q, old_q;

    tsmap_op_e        host_op;
    logic             host_oor, host_is_rmw, rmw_wr;
    logic [31:0]      old_word, new_word;

    function automatic logic [31:0] be_to_bitmask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    assign host_op     = tsmap_op_e'(host_op_i);
    assign host_oor    = 32'(host_addr_i) >= TSMapSize;
    assign host_is_rmw = (host_op == TSMAP_OP_BSET) || (host_op == TSMAP_OP_BCLR);
    assign host_gnt_o  = host_req_i & ~core_cs_i & (state_q == ST_IDLE);
    assign rmw_wr      = (state_q == ST_RMW_WR) & ~core_cs_i;

    // The old word arrives on the SRAM bus only in the first RMW_WR cycle; afterwards
    // the captured copy is used, so a deferred write still modifies the original value.
    assign old_word = rmw_first_q ? sram_rdata_i : old_q;
    assign new_word = rmw_set_q ? (old_word | rmw_mask_q) : (old_word & ~rmw_mask_q);

    always_comb begin
        sram_cs_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wmask_o = '0;
        sram_wdata_o = '0;
        if (core_cs_i) begin
            sram_cs_o   = 1'b1;
            sram_addr_o = core_addr_i;
        end else if (state_q == ST_RMW_WR) begin
            sram_cs_o    = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = rmw_addr_q;
            sram_wmask_o = '1;
            sram_wdata_o = new_word;
        end else if (host_gnt_o && !host_oor) begin
            sram_cs_o   = 1'b1;
            sram_addr_o = host_addr_i;
            if (host_op == TSMAP_OP_WRITE) begin
                sram_we_o    = 1'b1;
                sram_wmask_o = be_to_bitmask(host_be_i);
                sram_wdata_o = host_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            core_rd_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rmw_done_q  <= 1'b0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rmw_first_q <= 1'b0;
            rmw_set_q   <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_mask_q  <= '0;
            old_q       <= '0;
        end else begin
            core_rd_q  <= core_cs_i;
            rvalid_q   <= (host_gnt_o && (host_oor || !host_is_rmw)) || rmw_wr;
            err_q      <= host_gnt_o && host_oor;
            rd_pend_q  <= host_gnt_o && !host_oor && (host_op == TSMAP_OP_READ);
            rmw_done_q <= rmw_wr;
            unique case (state_q)
                ST_IDLE: begin
                    if (host_gnt_o && !host_oor && host_is_rmw) begin
                        state_q     <= ST_RMW_WR;
                        rmw_addr_q  <= host_addr_i;
                        rmw_mask_q  <= host_wdata_i;
                        rmw_set_q   <= (host_op == TSMAP_OP_BSET);
                        rmw_first_q <= 1'b1;
                    end
                end
                ST_RMW_WR: begin
                    if (rmw_first_q) begin
                        old_q       <= sram_rdata_i;
                        rmw_first_q <= 1'b0;
                    end
                    if (!core_cs_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_rdata_o  = core_rd_q ? sram_rdata_i : '0;
    assign host_rvalid_o = rvalid_q;
    assign host_err_o    = err_q;
    assign host_rdata_o  = rd_pend_q ? sram_rdata_i : (rmw_done_q ? old_q : '0);
    assign busy_o        = (state_q != ST_IDLE);

endmodule
